// File: rtl/usb_tx_phy_if.sv
// Byte-stream handshake and transceiver pin bundle for the USB 1.x transmit PHY.
interface usb_tx_phy_if;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_last_i;
  logic       tx_ready_o;
  logic       tx_busy_o;
  logic       tx_underrun_o;
  logic       usb_tx_dp_o;
  logic       usb_tx_dm_o;
  logic       usb_tx_oe_o;

  modport master (
    output tx_valid_i, tx_data_i, tx_last_i,
    input  tx_ready_o, tx_busy_o, tx_underrun_o,
    input  usb_tx_dp_o, usb_tx_dm_o, usb_tx_oe_o
  );

  modport slave (
    input  tx_valid_i, tx_data_i, tx_last_i,
    output tx_ready_o, tx_busy_o, tx_underrun_o,
    output usb_tx_dp_o, usb_tx_dm_o, usb_tx_oe_o
  );
endinterface

// File: rtl/usb_tx_phy.sv
// USB 1.x transmit PHY: SYNC, LSB-first data, bit-stuffing, NRZI, EOP.
// Define USB_TX_ABORT_STUFF_EN to abort underruns with a 7-ones stuff violation.
module usb_tx_phy #(
  parameter int unsigned SYS_CLK_FREQ = 24000000,
  parameter bit          USB_VER_1_X  = 1'b1
) (
  input logic         clk_i,
  input logic         rst_i,
  usb_tx_phy_if.slave bus
);
  localparam int unsigned BIT_CLKS = USB_VER_1_X ? SYS_CLK_FREQ / 12000000
                                                 : SYS_CLK_FREQ / 1500000;
  localparam int unsigned CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

  if (BIT_CLKS < 2) begin : g_bit_clks_check
    $error("usb_tx_phy: BIT_CLKS must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, EOP_SE0, EOP_J
`ifdef USB_TX_ABORT_STUFF_EN
    , ABORT
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic [7:0]    dat;
  logic          lst;
  logic [2:0]    ones;
  logic          stuff_q;
  logic          eop_pend;
  logic          line_j;
  logic [1:0]    pins;
  logic          oe;
  logic          busy;
  logic          underrun;
  logic          strobe;
  logic          handoff;

  // {dp, dm} for a line level; J polarity depends on the bus speed
  function automatic logic [1:0] sym(input logic j);
    return (j == USB_VER_1_X) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic nrzi(input logic line, input logic b);
    return b ? line : ~line;
  endfunction

  assign strobe  = (cnt == CW'(BIT_CLKS - 1));
  assign handoff = (state == DATA) && strobe && !stuff_q && (idx == 3'd7);

  assign bus.tx_ready_o    = !rst_i && ((state == IDLE) || (handoff && !lst));
  assign bus.tx_busy_o     = busy;
  assign bus.tx_underrun_o = underrun;
  assign bus.usb_tx_dp_o   = pins[1];
  assign bus.usb_tx_dm_o   = pins[0];
  assign bus.usb_tx_oe_o   = oe;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      dat      <= '0;
      lst      <= 1'b0;
      ones     <= '0;
      stuff_q  <= 1'b0;
      eop_pend <= 1'b0;
      line_j   <= 1'b1;
      pins     <= sym(1'b1);
      oe       <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (state != IDLE) cnt <= strobe ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (bus.tx_valid_i) begin
            // first SYNC bit (0) goes on the line together with acceptance
            state    <= SYNC;
            dat      <= bus.tx_data_i;
            lst      <= bus.tx_last_i;
            sh       <= 8'h40;
            idx      <= '0;
            ones     <= '0;
            stuff_q  <= 1'b0;
            eop_pend <= 1'b0;
            line_j   <= 1'b0;
            pins     <= sym(1'b0);
            oe       <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        SYNC: begin
          if (strobe) begin
            if (idx == 3'd7) begin
              state  <= DATA;
              sh     <= dat >> 1;
              idx    <= '0;
              line_j <= nrzi(line_j, dat[0]);
              pins   <= sym(nrzi(line_j, dat[0]));
              ones   <= dat[0] ? ones + 3'd1 : '0;
            end else begin
              sh     <= sh >> 1;
              idx    <= idx + 3'd1;
              line_j <= nrzi(line_j, sh[0]);
              pins   <= sym(nrzi(line_j, sh[0]));
              ones   <= sh[0] ? ones + 3'd1 : '0;
            end
          end
        end
        DATA: begin
          if (strobe) begin
            if (stuff_q && eop_pend) begin
              state <= EOP_SE0;
              idx   <= '0;
              pins  <= 2'b00;
            end else if (handoff) begin
              if (lst) begin
                if (ones == 3'd6) begin
                  eop_pend <= 1'b1;
                  stuff_q  <= 1'b1;
                  ones     <= '0;
                  line_j   <= ~line_j;
                  pins     <= sym(~line_j);
                end else begin
                  state <= EOP_SE0;
                  idx   <= '0;
                  pins  <= 2'b00;
                end
              end else if (bus.tx_valid_i) begin
                lst <= bus.tx_last_i;
                if (ones == 3'd6) begin
                  // idx stays 7 so the byte's first bit after the stuff wraps to 0
                  sh      <= bus.tx_data_i;
                  stuff_q <= 1'b1;
                  ones    <= '0;
                  line_j  <= ~line_j;
                  pins    <= sym(~line_j);
                end else begin
                  sh     <= bus.tx_data_i >> 1;
                  idx    <= '0;
                  line_j <= nrzi(line_j, bus.tx_data_i[0]);
                  pins   <= sym(nrzi(line_j, bus.tx_data_i[0]));
                  ones   <= bus.tx_data_i[0] ? ones + 3'd1 : '0;
                end
              end else begin
                underrun <= 1'b1;
                idx      <= '0;
`ifdef USB_TX_ABORT_STUFF_EN
                state    <= ABORT;
`else
                state    <= EOP_SE0;
                pins     <= 2'b00;
`endif
              end
            end else if (ones == 3'd6) begin
              stuff_q <= 1'b1;
              ones    <= '0;
              line_j  <= ~line_j;
              pins    <= sym(~line_j);
            end else begin
              stuff_q <= 1'b0;
              sh      <= sh >> 1;
              idx     <= idx + 3'd1;
              line_j  <= nrzi(line_j, sh[0]);
              pins    <= sym(nrzi(line_j, sh[0]));
              ones    <= sh[0] ? ones + 3'd1 : '0;
            end
          end
        end
`ifdef USB_TX_ABORT_STUFF_EN
        ABORT: begin
          if (strobe) begin
            if (idx == 3'd6) begin
              state <= EOP_SE0;
              idx   <= '0;
              pins  <= 2'b00;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
`endif
        EOP_SE0: begin
          if (strobe) begin
            if (idx == 3'd1) begin
              state  <= EOP_J;
              line_j <= 1'b1;
              pins   <= sym(1'b1);
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        EOP_J: begin
          if (strobe) begin
            state   <= IDLE;
            oe      <= 1'b0;
            busy    <= 1'b0;
            ones    <= '0;
            stuff_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_phy.sv
// Directed bench for usb_tx_phy at 24 MHz full speed (2 clocks per bit).
module tb_usb_tx_phy;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // sample = {busy, ready, underrun, oe, dp, dm}
  localparam logic [5:0] IDLE_S = 6'b010010;
  localparam logic [5:0] RST_S  = 6'b000010;

  logic [5:0] exp_q[$];
  logic       mline;
  int         mones;
  logic       und_pend;

  usb_tx_phy_if bus();

  usb_tx_phy #(.SYS_CLK_FREQ(24000000), .USB_VER_1_X(1'b1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] sample();
    return {bus.tx_busy_o, bus.tx_ready_o, bus.tx_underrun_o,
            bus.usb_tx_oe_o, bus.usb_tx_dp_o, bus.usb_tx_dm_o};
  endfunction

  function automatic logic [1:0] lsym(input logic j);
    return j ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [1:0] s, input logic rdy);
    exp_q.push_back({1'b1, 1'b0, und_pend, 1'b1, s});
    exp_q.push_back({1'b1, rdy, 1'b0, 1'b1, s});
    und_pend = 1'b0;
  endtask

  task automatic model_bit(input logic b, input logic rdy, input logic allow_stuff);
    if (!b) mline = ~mline;
    push_sym(lsym(mline), rdy);
    mones = b ? mones + 1 : 0;
    if (mones == 6 && allow_stuff) begin
      mline = ~mline;
      push_sym(lsym(mline), 1'b0);
      mones = 0;
    end
  endtask

  task automatic build(input logic [7:0] b[4], input int n, input logic fin_last);
    logic [7:0] sync;
    logic       fin;
    sync = 8'h80;
    exp_q.delete();
    mline = 1'b1;
    mones = 0;
    und_pend = 1'b0;
    for (int i = 0; i < 8; i++) model_bit(sync[i], 1'b0, 1'b1);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        fin = (k == n - 1);
        model_bit(b[k][i], (i == 7) && !(fin && fin_last), !(fin && !fin_last && i == 7));
      end
    end
    if (!fin_last) begin
      und_pend = 1'b1;
`ifdef USB_TX_ABORT_STUFF_EN
      for (int i = 0; i < 7; i++) push_sym(lsym(mline), 1'b0);
`endif
    end
    push_sym(2'b00, 1'b0);
    push_sym(2'b00, 1'b0);
    push_sym(2'b10, 1'b0);
    exp_q.push_back(IDLE_S);
  endtask

  task automatic send(input logic [7:0] b[4], input int n, input logic fin_last,
                      input int limit, input string tag);
    logic [5:0] obs;
    int         bi;
    logic       pend;
    build(b, n, fin_last);
    @(negedge clk);
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = b[0];
    bus.tx_last_i  = (n == 1) ? fin_last : 1'b0;
    check({tag, " idle"}, sample(), IDLE_S);
    @(posedge clk);
    bi   = 0;
    pend = 1'b1;
    for (int c = 0; c < limit && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (pend) begin
        bi++;
        pend = 1'b0;
        if (bi < n) begin
          bus.tx_data_i = b[bi];
          bus.tx_last_i = (bi == n - 1) ? fin_last : 1'b0;
        end else begin
          bus.tx_valid_i = 1'b0;
        end
      end
      obs = sample();
      check($sformatf("%s c%0d", tag, c), obs, exp_q.pop_front());
      if (obs[4] && bus.tx_valid_i) pend = 1'b1;
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.tx_valid_i = 1'b0;
    bus.tx_data_i  = 8'h00;
    bus.tx_last_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", sample(), RST_S);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", sample(), IDLE_S);

    send('{8'hA5, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1000, "a5");
    send('{8'hFF, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1000, "ff");
    send('{8'hFC, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1000, "fc");
    send('{8'h12, 8'h34, 8'h00, 8'h00}, 2, 1'b1, 1000, "12_34");
    send('{8'h12, 8'h00, 8'h00, 8'h00}, 1, 1'b0, 1000, "underrun");
    send('{8'h3F, 8'hFF, 8'h7E, 8'h00}, 3, 1'b1, 1000, "stuff_multi");

    // stop during the third data bit, then reset with a byte offered
    send('{8'h12, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 21, "pre_rst");
    rst = 1'b1;
    bus.tx_valid_i = 1'b1;
    bus.tx_data_i  = 8'h55;
    bus.tx_last_i  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_packet", sample(), RST_S);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold", sample(), RST_S);
    bus.tx_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_mid_rst", sample(), IDLE_S);
    send('{8'h3C, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1000, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
